// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM PIO family: register addresses, edge-mode
// encodings and the bus data width.
package pio_pkg;

  localparam int PIO_DW = 32;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_chain.sv
// Multi-flop synchroniser for a bus of asynchronous pins; every stage clears on
// reset so the chain starts from a known all-zero state.
module pio_sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // NOTE: the chain is a handful of flops, not a RAM, so clearing every stage
  // on reset is cheap and keeps the warm-up behaviour deterministic.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/pio_in_edge.sv
// Avalon-MM input PIO: synchronised pin level, sticky edge capture with
// write-one-to-clear, and a maskable interrupt.
module pio_in_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int IRQ_LEVEL   = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [PIO_DW-1:0] writedata,
  output logic [PIO_DW-1:0] readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  localparam logic [2:0] WARM_TC = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]  data_sync;
  logic [WIDTH-1:0]  prev;
  logic [WIDTH-1:0]  irq_mask;
  logic [WIDTH-1:0]  edge_cap;
  logic [WIDTH-1:0]  edge_raw;
  logic [WIDTH-1:0]  edge_det;
  logic [WIDTH-1:0]  cap_clr;
  logic [2:0]        warm_cnt;
  logic              warm_done;
  logic              wr_en;
  logic [PIO_DW-1:0] rd_mux;
  logic              unused_wdata;

  pio_sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (data_sync)
  );

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_raw = ~data_sync & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign edge_raw = data_sync ^ prev;
    end else begin : g_rise
      assign edge_raw = data_sync & ~prev;
    end
  endgenerate

  // Until the chain and prev hold real pin samples, zero-to-high transitions
  // inside the pipeline are artefacts of reset, not pin edges.
  assign warm_done = (warm_cnt == WARM_TC);
  assign edge_det  = warm_done ? edge_raw : '0;
  assign wr_en     = chipselect && !write_n;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cap_clr = '0;
    if (wr_en && address == PIO_ADDR_EDGECAP) cap_clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      PIO_ADDR_DATA:    rd_mux = PIO_DW'(data_sync);
      PIO_ADDR_IRQMASK: rd_mux = PIO_DW'(irq_mask);
      PIO_ADDR_EDGECAP: rd_mux = PIO_DW'(edge_cap);
      default:          rd_mux = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev     <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      warm_cnt <= '0;
      readdata <= '0;
    end else begin
      prev     <= data_sync;
      readdata <= rd_mux;
      if (!warm_done) warm_cnt <= warm_cnt + 3'd1;
      if (wr_en && address == PIO_ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      // Set is applied after clear so a same-cycle edge is never lost.
      edge_cap <= (edge_cap & ~cap_clr) | edge_det;
    end
  end

  generate
    if (IRQ_LEVEL != 0) begin : g_irq_level
      assign irq = |(data_sync & irq_mask);
    end else begin : g_irq_edge
      assign irq = |(edge_cap & irq_mask);
    end
  endgenerate

  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_pio_in_edge.sv
// Scoreboard bench for pio_in_edge across four configurations sharing one bus.
module tb_pio_in_edge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_a, in_b, in_c;
  logic [31:0] in_w;
  logic [31:0] rd_a, rd_b, rd_c, rd_w;
  logic        irq_a, irq_b, irq_c, irq_w;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, e;

  always #5 clk = ~clk;

  pio_in_edge #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_LEVEL(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_a), .irq(irq_a));
  pio_in_edge #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_LEVEL(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_b), .irq(irq_b));
  pio_in_edge #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_LEVEL(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_c), .in_port(in_c), .irq(irq_c));
  pio_in_edge #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(0), .IRQ_LEVEL(0)) dut_w (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_w), .in_port(in_w), .irq(irq_w));

  function automatic logic [31:0] pick(input int d);
    case (d)
      0:       return rd_a;
      1:       return rd_b;
      2:       return rd_c;
      default: return rd_w;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input int d, input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk);
    #1;
    v = pick(d);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = data;
    @(posedge clk);
    #1;
    write_n = 1'b1; chipselect = 1'b0;
  endtask

  task automatic sb_cmp(input logic [31:0] v, input string name);
    e = exp_q.pop_front();
    checks++;
    if (v !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, v, e);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
    in_a = 4'hF; in_b = 4'hF; in_c = 4'hF; in_w = 32'h0;
    step(3);
    exp_q.push_back(32'h0);
    sb_cmp(rd_a, "reset_readdata");
    checks++;
    if (irq_a !== 1'b0) begin errors++; $display("FAIL reset_irq got %b expected 0", irq_a); end
    @(negedge clk);
    reset_n = 1'b1;
    step(10);
    exp_q.push_back(32'hF);
    bus_read(0, 2'd0, got); sb_cmp(got, "warm_data");
    exp_q.push_back(32'h0);
    bus_read(0, 2'd3, got); sb_cmp(got, "warm_edgecap");
    exp_q.push_back(32'h0);
    bus_read(1, 2'd3, got); sb_cmp(got, "warm_edgecap_any");
    checks++;
    if (irq_a !== 1'b0) begin errors++; $display("FAIL warm_irq got %b expected 0", irq_a); end
    @(negedge clk);
    in_a = 4'h0; in_b = 4'h0; in_c = 4'h0;
    step(5);
    bus_write(2'd3, 32'hFFFF_FFFF);
  endtask

  task automatic test_rising;
    bus_write(2'd2, 32'h5);
    @(negedge clk);
    in_a = 4'h3; address = 2'd3; chipselect = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h3);
    step(1);
    checks++;
    if (irq_a !== 1'b0) begin errors++; $display("FAIL rise_irq_k got %b expected 0", irq_a); end
    step(1);
    checks++;
    if (irq_a !== 1'b0) begin errors++; $display("FAIL rise_irq_k1 got %b expected 0", irq_a); end
    step(1);
    checks++;
    if (irq_a !== 1'b1) begin errors++; $display("FAIL rise_irq_k2 got %b expected 1", irq_a); end
    sb_cmp(rd_a, "rise_cap_k2");
    step(1);
    sb_cmp(rd_a, "rise_cap_k3");
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq_a !== 1'b0) begin errors++; $display("FAIL rise_clear_irq got %b expected 0", irq_a); end
    exp_q.push_back(32'h2);
    bus_read(0, 2'd3, got); sb_cmp(got, "rise_clear_cap");
  endtask

  task automatic test_collision;
    @(negedge clk);
    in_b = 4'h1;
    step(4);
    exp_q.push_back(32'h1);
    bus_read(1, 2'd3, got); sb_cmp(got, "coll_pre");
    @(negedge clk);
    in_b = 4'h0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    bus_write(2'd3, 32'h1);
    exp_q.push_back(32'h1);
    bus_read(1, 2'd3, got); sb_cmp(got, "coll_set_wins");
    bus_write(2'd3, 32'h1);
    exp_q.push_back(32'h0);
    bus_read(1, 2'd3, got); sb_cmp(got, "coll_plain_clear");
  endtask

  task automatic test_level;
    bus_write(2'd2, 32'h8);
    @(negedge clk);
    in_c = 4'h8;
    step(1);
    checks++;
    if (irq_c !== 1'b0) begin errors++; $display("FAIL lvl_rise_k got %b expected 0", irq_c); end
    step(1);
    checks++;
    if (irq_c !== 1'b1) begin errors++; $display("FAIL lvl_rise_k1 got %b expected 1", irq_c); end
    @(negedge clk);
    in_c = 4'h0;
    step(1);
    checks++;
    if (irq_c !== 1'b1) begin errors++; $display("FAIL lvl_fall_k got %b expected 1", irq_c); end
    step(1);
    checks++;
    if (irq_c !== 1'b0) begin errors++; $display("FAIL lvl_fall_k1 got %b expected 0", irq_c); end
    exp_q.push_back(32'h8);
    bus_read(2, 2'd3, got); sb_cmp(got, "lvl_edgecap");
  endtask

  task automatic test_wide;
    @(negedge clk);
    in_w = 32'hA5A5_A5A5; address = 2'd0; chipselect = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hA5A5_A5A5);
    step(3);
    sb_cmp(rd_w, "wide_data_k2");
    step(1);
    sb_cmp(rd_w, "wide_data_k3");
    exp_q.push_back(32'h0);
    bus_read(3, 2'd1, got); sb_cmp(got, "wide_reserved");
    bus_write(2'd0, 32'hFFFF_FFFF);
    exp_q.push_back(32'hA5A5_A5A5);
    bus_read(3, 2'd0, got); sb_cmp(got, "wide_data_ro");
    bus_write(2'd2, 32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFFF);
    bus_read(3, 2'd2, got); sb_cmp(got, "wide_mask");
    exp_q.push_back(32'h0000_000F);
    bus_read(0, 2'd2, got); sb_cmp(got, "narrow_mask_trunc");
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    in_a = 4'h0;
    step(4);
    @(negedge clk);
    in_a = 4'hF;
    step(4);
    exp_q.push_back(32'hF);
    bus_read(0, 2'd3, got); sb_cmp(got, "mid_pre_cap");
    checks++;
    if (irq_a !== 1'b1) begin errors++; $display("FAIL mid_pre_irq got %b expected 1", irq_a); end
    @(negedge clk);
    reset_n = 1'b0;
    step(1);
    exp_q.push_back(32'h0);
    sb_cmp(rd_a, "mid_rst_readdata");
    checks++;
    if ({irq_a, irq_b, irq_c, irq_w} !== 4'b0) begin
      errors++; $display("FAIL mid_rst_irq got %b expected 0000", {irq_a, irq_b, irq_c, irq_w});
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(32'h0);
    bus_read(0, 2'd2, got); sb_cmp(got, "mid_mask_cleared");
    step(5);
    exp_q.push_back(32'h0);
    bus_read(0, 2'd3, got); sb_cmp(got, "mid_cap_cleared");
    exp_q.push_back(32'hF);
    bus_read(0, 2'd0, got); sb_cmp(got, "mid_data");
  endtask

  initial begin
    test_reset();
    test_rising();
    test_collision();
    test_level();
    test_wide();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
